logic_reduce_acc: RTL and testbench



---
 rtl/logic_reduce_pkg.sv | 44 ++++
 rtl/logic_reduce_acc_reduce_comb.sv | 24 ++
 rtl/logic_reduce_acc.sv | 118 +++++++++++
 tb/tb_logic_reduce_acc.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_reduce_pkg.sv
// Shared types and operator helpers for the multi-channel bitwise reduction unit.
// Helpers work on MAX_W-bit words; callers zero-extend and truncate with casts.
package logic_reduce_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    MODE_OR  = 2'b00,
    MODE_AND = 2'b01,
    MODE_XOR = 2'b10,
    MODE_NOR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic [MAX_W-1:0] identity(input mode_e m);
    logic [MAX_W-1:0] r;
    case (m)
      MODE_AND: r = '1;
      default:  r = '0;
    endcase
    return r;
  endfunction

  // NOR folds as OR; its inversion happens once, when the result is loaded
  function automatic logic [MAX_W-1:0] apply(input mode_e m,
                                             input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] r;
    case (m)
      MODE_OR:  r = a | b;
      MODE_AND: r = a & b;
      MODE_XOR: r = a ^ b;
      MODE_NOR: r = a | b;
      default:  r = a | b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_reduce_acc_reduce_comb.sv
// Combinational fold of NCH channels into one WIDTH-bit word under the given operator.
module reduce_comb
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) (
  input  mode_e              mode,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]     out_data
);

  logic [WIDTH-1:0] fold_s;

  // Start from the operator identity so NCH=1 is a pass-through
  always_comb begin
    fold_s = WIDTH'(identity(mode));
    for (int c = 0; c < NCH; c++) begin
      fold_s = WIDTH'(apply(mode, MAX_W'(fold_s), MAX_W'(in_data[c*WIDTH +: WIDTH])));
    end
    out_data = fold_s;
  end

endmodule

// File: rtl/logic_reduce_acc.sv
// Frame accumulator: reduces each beat across channels, folds beats over a frame
// and presents the registered result on a valid/ready output.
module logic_reduce_acc
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2,
  parameter int BEATS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NCH*WIDTH-1:0]       in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(BEATS+1)-1:0] out_beats
);

  localparam int CW = $clog2(BEATS + 1);

  state_e           state_r;
  mode_e            mode_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [CW-1:0]    out_beats_r;

  mode_e            beat_mode_s;
  logic [WIDTH-1:0] red_s;
  logic [WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0] out_next_s;
  logic [CW-1:0]    cnt_next_s;
  logic             frame_end_s;
  logic             accept_s;

  assign in_ready  = (state_r != ST_DONE);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_beats = out_beats_r;

  reduce_comb #(.WIDTH(WIDTH), .NCH(NCH)) u_reduce (
    .mode    (beat_mode_s),
    .in_data (in_data),
    .out_data(red_s)
  );

  // Next accumulator/count; the live mode port only matters on a frame's first beat
  always_comb begin
    beat_mode_s = mode_r;
    acc_next_s  = acc_r;
    cnt_next_s  = cnt_r;
    if (state_r == ST_IDLE) begin
      beat_mode_s = mode_e'(mode);
      acc_next_s  = red_s;
      cnt_next_s  = CW'(1);
    end else begin
      beat_mode_s = mode_r;
      acc_next_s  = WIDTH'(apply(mode_r, MAX_W'(acc_r), MAX_W'(red_s)));
      cnt_next_s  = cnt_r + CW'(1);
    end
    frame_end_s = in_last || (cnt_next_s == CW'(BEATS));
    if (beat_mode_s == MODE_NOR) begin
      out_next_s = ~acc_next_s;
    end else begin
      out_next_s = acc_next_s;
    end
  end

  // Frame FSM with accumulator, counter and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      mode_r      <= MODE_OR;
      acc_r       <= '0;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_beats_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_ACC: begin
          if (accept_s) begin
            if (state_r == ST_IDLE) begin
              mode_r <= mode_e'(mode);
            end
            acc_r <= acc_next_s;
            cnt_r <= cnt_next_s;
            if (frame_end_s) begin
              out_data_r  <= out_next_s;
              out_beats_r <= cnt_next_s;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              state_r <= ST_ACC;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_reduce_acc.sv
// Self-checking bench for logic_reduce_acc: directed scenarios plus randomized frames
// compared against a per-bit counting reference model.
module tb_logic_reduce_acc;

  localparam int WIDTH = 8;
  localparam int NCH   = 2;
  localparam int BEATS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [2:0]  out_beats;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic_reduce_acc #(.WIDTH(WIDTH), .NCH(NCH), .BEATS(BEATS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_beats(out_beats)
  );

  // Each result bit depends only on how many channel words in the frame have that bit set
  function automatic logic [7:0] model_result(input logic [1:0] m, input logic [7:0] words[$]);
    logic [7:0] r;
    int ones;
    r = 8'h00;
    for (int b = 0; b < 8; b++) begin
      ones = 0;
      foreach (words[i]) ones += int'(words[i][b]);
      case (m)
        2'd0:    r[b] = (ones > 0);
        2'd1:    r[b] = (ones == words.size());
        2'd2:    r[b] = ones[0];
        default: r[b] = (ones == 0);
      endcase
    end
    return r;
  endfunction

  task automatic send_beat(input logic [1:0] m, input logic [7:0] c0, input logic [7:0] c1,
                           input logic last);
    @(negedge clk);
    mode = m; in_data = {c1, c0}; in_last = last; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic handshake;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
    checks++; if (out_beats !== 3'd0) begin errors++; $display("FAIL reset_beats: got %0d want 0", out_beats); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_or_frame;
    send_beat(2'b00, 8'h01, 8'h02, 1'b0);
    send_beat(2'b00, 8'h04, 8'h00, 1'b0);
    send_beat(2'b00, 8'h00, 8'h10, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL or_early_valid: got %b want 0", out_valid); end
    send_beat(2'b00, 8'h80, 8'h00, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL or_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 8'h97) begin errors++; $display("FAIL or_data: got %h want 97", out_data); end
    checks++; if (out_beats !== 3'd4) begin errors++; $display("FAIL or_beats: got %0d want 4", out_beats); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL or_ready_low: got %b want 0", in_ready); end
    handshake;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL or_valid_clear: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL or_ready_back: got %b want 1", in_ready); end
  endtask

  task automatic test_and_early;
    send_beat(2'b01, 8'hFF, 8'hF0, 1'b0);
    send_beat(2'b01, 8'h3C, 8'hFF, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL and_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 8'h30) begin errors++; $display("FAIL and_data: got %h want 30", out_data); end
    checks++; if (out_beats !== 3'd2) begin errors++; $display("FAIL and_beats: got %0d want 2", out_beats); end
    handshake;
  endtask

  task automatic test_xor_frame;
    send_beat(2'b10, 8'hAA, 8'h55, 1'b0);
    send_beat(2'b10, 8'hFF, 8'h00, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL xor_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL xor_data: got %h want 00", out_data); end
    checks++; if (out_beats !== 3'd2) begin errors++; $display("FAIL xor_beats: got %0d want 2", out_beats); end
    handshake;
  endtask

  task automatic test_nor_latch;
    send_beat(2'b11, 8'h00, 8'h01, 1'b0);
    send_beat(2'b01, 8'h02, 8'h00, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nor_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 8'hFC) begin errors++; $display("FAIL nor_data: got %h want fc", out_data); end
    checks++; if (out_beats !== 3'd2) begin errors++; $display("FAIL nor_beats: got %0d want 2", out_beats); end
    handshake;
  endtask

  task automatic test_backpressure;
    send_beat(2'b00, 8'h11, 8'h22, 1'b1);
    @(negedge clk);
    mode = 2'b01; in_data = 16'hFFFF; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (out_data !== 8'h33) begin errors++; $display("FAIL bp_data[%0d]: got %h want 33", i, out_data); end
      checks++; if (out_beats !== 3'd1) begin errors++; $display("FAIL bp_beats[%0d]: got %0d want 1", i, out_beats); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    handshake;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b want 0", out_valid); end
    send_beat(2'b00, 8'h01, 8'h00, 1'b1);
    checks++; if (out_data !== 8'h01) begin errors++; $display("FAIL bp_next_data: got %h want 01", out_data); end
    checks++; if (out_beats !== 3'd1) begin errors++; $display("FAIL bp_next_beats: got %0d want 1", out_beats); end
    handshake;
  endtask

  task automatic test_reset_mid_frame;
    send_beat(2'b00, 8'h01, 8'h02, 1'b0);
    send_beat(2'b00, 8'h04, 8'h08, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h want 00", out_data); end
    checks++; if (out_beats !== 3'd0) begin errors++; $display("FAIL mid_rst_beats: got %0d want 0", out_beats); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    send_beat(2'b00, 8'h0F, 8'hF0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 8'hFF) begin errors++; $display("FAIL post_rst_data: got %h want ff", out_data); end
    checks++; if (out_beats !== 3'd1) begin errors++; $display("FAIL post_rst_beats: got %0d want 1", out_beats); end
    handshake;
  endtask

  task automatic test_random;
    logic [1:0] m;
    logic [7:0] c0, c1, exp;
    logic       last;
    logic [7:0] words[$];
    int n, hold;
    for (int f = 0; f < 40; f++) begin
      m = 2'($urandom_range(0, 3));
      n = $urandom_range(1, BEATS);
      words.delete();
      for (int k = 0; k < n; k++) begin
        c0 = 8'($urandom); c1 = 8'($urandom);
        words.push_back(c0); words.push_back(c1);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        last = (k == n - 1) && ((n < BEATS) || ($urandom_range(0, 1) == 1));
        send_beat((k == 0) ? m : 2'($urandom_range(0, 3)), c0, c1, last);
        if (k < n - 1) begin
          checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_early_valid f%0d k%0d: got %b want 0", f, k, out_valid); end
        end
      end
      exp = model_result(m, words);
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold; h++) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rnd_valid f%0d: got %b want 1", f, out_valid); end
        checks++; if (out_data !== exp) begin errors++; $display("FAIL rnd_data f%0d mode %0d: got %h want %h", f, m, out_data, exp); end
        checks++; if (out_beats !== 3'(n)) begin errors++; $display("FAIL rnd_beats f%0d: got %0d want %0d", f, out_beats, n); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rnd_ready f%0d: got %b want 0", f, in_ready); end
        if (h < hold) begin @(posedge clk); #1; end
      end
      handshake;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_clear f%0d: got %b want 0", f, out_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_or_frame();
    test_and_early();
    test_xor_frame();
    test_nor_latch();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
